// File: rtl/mac_pkg.sv
// Shared sizing helpers for the mac_dot dot-product block.
package mac_pkg;

    function automatic int mac_aw(input int n, input int g);
        return 2 * n + g;
    endfunction

    localparam int N_DEF  = 16;
    localparam int G_DEF  = 8;
    localparam int AW_DEF = mac_aw(N_DEF, G_DEF);

    // Signed extremes of the default-width accumulator.
    localparam logic [AW_DEF-1:0] AW_MAX_DEF = {1'b0, {(AW_DEF-1){1'b1}}};
    localparam logic [AW_DEF-1:0] AW_MIN_DEF = {1'b1, {(AW_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_dot_sat_adder.sv
// Combinational W-bit signed adder with overflow detect and optional clamp.
module sat_adder #(
    parameter int W   = 40,
    parameter bit SAT = 1'b0
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);
    logic signed [W-1:0] raw;

    assign raw = a + b;
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

    // On overflow both operands share a sign, so b's sign picks the rail.
    always_comb begin
        sum = raw;
        if (SAT && ovf)
            sum = b[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

endmodule

// File: rtl/mac_dot.sv
// Two-stage pipelined signed MAC producing one result per LEN accepted terms.
module mac_dot
    import mac_pkg::*;
#(
    parameter int N   = 16,
    parameter int G   = 8,
    parameter int LEN = 4,
    parameter bit SAT = 1'b0,
    localparam int AW = mac_aw(N, G)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [N-1:0]  x1,
    input  logic signed [N-1:0]  x2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] y,
    output logic                 ovf
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    typedef struct packed {
        logic signed [2*N-1:0] prod;
        logic                  last;
    } s1_t;

    s1_t                 s1;
    logic                p_valid;
    logic [CW-1:0]       cnt;
    logic signed [AW-1:0] acc;
    logic                ovf_acc;
    logic                first;

    logic                stall, accept, retire, cnt_last;
    logic signed [AW-1:0] add_a, add_b, sum;
    logic                add_ovf, ovf_prev;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~clr;
    assign accept   = in_valid & in_ready;
    assign retire   = p_valid & ~stall;
    assign cnt_last = (cnt == CW'(LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= '0;
            p_valid <= 1'b0;
            cnt     <= '0;
        end else if (clr) begin
            p_valid <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            s1.prod <= (2*N)'(x1) * (2*N)'(x2);
            s1.last <= cnt_last;
            p_valid <= 1'b1;
            cnt     <= cnt_last ? '0 : cnt + 1'b1;
        end else if (!stall) begin
            p_valid <= 1'b0;
        end
    end

    // The first term of each result starts from zero instead of the old acc.
    assign add_a    = first ? '0 : acc;
    assign add_b    = AW'(s1.prod);
    assign ovf_prev = first ? 1'b0 : ovf_acc;

    sat_adder #(.W(AW), .SAT(SAT)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            first     <= 1'b1;
            y         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            ovf_acc   <= 1'b0;
            first     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (retire) begin
                first   <= s1.last;
                ovf_acc <= ovf_prev | add_ovf;
                if (s1.last) begin
                    y         <= sum;
                    ovf       <= ovf_prev | add_ovf;
                    out_valid <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_dot.sv
// Directed checks of mac_dot across wrap, saturate and LEN=1 configurations.
module tb_mac_dot;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [15:0] x1 = '0, x2 = '0;

    logic rdy0, rdy1, rdy2, rdy3;
    logic ov0, ov1, ov2, ov3;
    logic of0, of1, of2, of3;
    logic signed [39:0] y0, y3;
    logic signed [31:0] y1, y2;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mac_dot #(.N(16), .G(8), .LEN(4), .SAT(1'b0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .x1(x1), .x2(x2), .out_valid(ov0), .out_ready(out_ready), .y(y0), .ovf(of0));
    mac_dot #(.N(16), .G(0), .LEN(4), .SAT(1'b0)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .x1(x1), .x2(x2), .out_valid(ov1), .out_ready(out_ready), .y(y1), .ovf(of1));
    mac_dot #(.N(16), .G(0), .LEN(4), .SAT(1'b1)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
        .x1(x1), .x2(x2), .out_valid(ov2), .out_ready(out_ready), .y(y2), .ovf(of2));
    mac_dot #(.N(16), .G(8), .LEN(1), .SAT(1'b0)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy3),
        .x1(x1), .x2(x2), .out_valid(ov3), .out_ready(out_ready), .y(y3), .ovf(of3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic signed [15:0] a, input logic signed [15:0] b);
        x1 = a; x2 = b; in_valid = 1'b1;
        cyc();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic pulse_clr();
        in_valid = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_y", y0, 64'd0);
        chk("rst_ov", ov0, 64'd0);
        chk("rst_ovf", of0, 64'd0);
        #20 rst = 1'b1;
        #1;
        chk("rst_rdy", rdy0, 64'd1);

        // 1: basic dot product and latency
        feed(1, 5); feed(2, 6); feed(3, 7); feed(4, 8);
        in_valid = 1'b0;
        chk("t1_lat", ov0, 64'd0);
        cyc();
        chk("t1_ov", ov0, 64'd1);
        chk("t1_y", y0, 64'd70);
        chk("t1_ovf", of0, 64'd0);
        cyc();
        chk("t1_once", ov0, 64'd0);

        // 2: extreme operands fit in guard bits, then cancellation
        repeat (4) feed(-16'sd32768, -16'sd32768);
        idle();
        chk("t2_y", y0, 64'h1_0000_0000);
        chk("t2_ovf", of0, 64'd0);
        feed(-1, 3); feed(1, 3); feed(-1, 3); feed(1, 3);
        idle();
        chk("t2_ov", ov0, 64'd1);
        chk("t2_y0", y0, 64'd0);

        // 3: no guard bits, wrap vs saturate
        pulse_clr();
        repeat (4) feed(-16'sd32768, -16'sd32768);
        idle();
        chk("t3_wrap_y", y1, 64'd0);
        chk("t3_wrap_ovf", of1, 64'd1);
        chk("t3_sat_y", y2, 64'h7FFF_FFFF);
        chk("t3_sat_ovf", of2, 64'd1);
        chk("t3_g8_y", y0, 64'h1_0000_0000);
        cyc();

        // 4: backpressure holds result and input
        feed(1, 5); feed(2, 6); feed(3, 7); feed(4, 8);
        out_ready = 1'b0;
        feed(1, 2);
        x1 = 3; x2 = 4;
        chk("t4_rdy0", rdy0, 64'd0);
        chk("t4_y", y0, 64'd70);
        chk("t4_ov", ov0, 64'd1);
        cyc();
        chk("t4_hold_y", y0, 64'd70);
        chk("t4_hold_rdy", rdy0, 64'd0);
        out_ready = 1'b1;
        #1;
        chk("t4_rdy1", rdy0, 64'd1);
        cyc();
        chk("t4_drain", ov0, 64'd0);
        feed(5, 6); feed(7, 8);
        idle();
        chk("t4_y2", y0, 64'd100);
        chk("t4_ov2", ov0, 64'd1);

        // 5: clr discards partial sum
        pulse_clr();
        feed(1, 5); feed(2, 6);
        clr = 1'b1; x1 = 1; x2 = 2; in_valid = 1'b1;
        #1;
        chk("t5_rdy_clr", rdy0, 64'd0);
        cyc();
        clr = 1'b0;
        chk("t5_ov_clr", ov0, 64'd0);
        repeat (4) feed(1, 2);
        in_valid = 1'b0;
        chk("t5_nospur", ov0, 64'd0);
        cyc();
        chk("t5_y", y0, 64'd8);
        chk("t5_ov", ov0, 64'd1);

        // 6: async reset mid-term and with a pending result
        feed(1, 5); feed(2, 6);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t6_mid_y", y0, 64'd0);
        chk("t6_mid_ov", ov0, 64'd0);
        #3 rst = 1'b1;
        feed(1, 5); feed(2, 6); feed(3, 7); feed(4, 8);
        out_ready = 1'b0;
        idle();
        chk("t6_pend", ov0, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_pend_y", y0, 64'd0);
        chk("t6_pend_ov", ov0, 64'd0);
        #3 rst = 1'b1; out_ready = 1'b1;
        feed(1, 5); feed(2, 6); feed(3, 7); feed(4, 8);
        idle();
        chk("t6_again_y", y0, 64'd70);

        // LEN=1: every accepted term is a result
        pulse_clr();
        feed(3, -4);
        for (int i = 0; i < 3; i++) begin
            feed(3, -4);
            chk("len1_y", y3, 64'(-64'sd12));
            chk("len1_ov", ov3, 64'd1);
        end
        idle();

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: no finish within 50000 time units");
        $fatal(1, "timeout");
    end
endmodule
